crc_rx_check: RTL and testbench
===============================

CRC_RX_CHECK -- requirements
Module: crc_rx_check

Interface
REQ-001 Parameter CRC_WIDTH, default 32, width of the CRC values compared.
REQ-002 Parameter DEPTH, default 16, power of two >= 2, expected-CRC queue depth.
REQ-003 Parameter PKT_LIMIT, 8 bits, default 8'd100, number of compared packets after which the check completes.
REQ-004 clk  input  1  the single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 exp_crc  input  CRC_WIDTH  reference CRC of one packet, supplied by the stream source.
REQ-007 exp_vld  input  1  exp_crc valid this cycle, one pulse per packet.
REQ-008 crc_out  input  CRC_WIDTH  CRC result from the CRC engine under test.
REQ-009 crc_out_vld  input  1  crc_out valid this cycle, one pulse per packet.
REQ-010 pass_cnt  output  8  packets whose CRCs matched.
REQ-011 fail_cnt  output  8  packets whose CRCs mismatched; saturates at 8'hFF.
REQ-012 first_fail_idx  output  8  packet index (0-based) of the first mismatch.
REQ-013 done  output  1  PKT_LIMIT packets compared.
REQ-014 fault  output  1  protocol fault: queue overflow or orphan result.
REQ-015 pending  output  $clog2(DEPTH)+1  expected CRCs queued but not yet compared.

Function
REQ-016 States: IDLE, RUN, DONE, FAULT; IDLE -> RUN on the first exp_vld or crc_out_vld; RUN -> DONE when the compared count reaches PKT_LIMIT; RUN -> FAULT on any protocol fault; DONE and FAULT exit only through rst.
REQ-017 exp_vld pushes exp_crc into an in-order queue in IDLE or RUN.
REQ-018 crc_out_vld pops the queue head and compares it with crc_out in the same cycle.
REQ-019 Push and pop in the same cycle: both take effect and pending is unchanged.
REQ-020 Push and pop in the same cycle with the queue empty: exp_crc bypasses the queue and is compared directly; this is not a fault.
REQ-021 Comparison result registers one cycle after crc_out_vld:
- equal: pass_cnt +1
- unequal: fail_cnt +1; first_fail_idx captured only on the first failure.
REQ-022 Packet index is the running compared count, pass plus fail, wrapping mod 256.
REQ-023 Push while full without a simultaneous pop is overflow: the entry is dropped, fault=1, state goes to FAULT.
REQ-024 crc_out_vld while the queue is empty and exp_vld=0 is an orphan result: no counter changes, fault=1, state goes to FAULT.
REQ-025 done asserts the cycle after the PKT_LIMIT-th comparison registers.
REQ-026 In DONE or FAULT, further exp_vld and crc_out_vld are ignored and all outputs hold.
REQ-027 pending equals pushes minus pops, range 0..DEPTH; queue pointers wrap mod DEPTH.
REQ-028 PKT_LIMIT=0: done never asserts.

Reset
REQ-029 On rst=1 at a clock edge:
- state IDLE
- queue emptied, pending=0
- pass_cnt=0, fail_cnt=0, first_fail_idx=8'hFF
- done=0, fault=0.
REQ-030 rst mid-packet discards all queued entries; a crc_out_vld arriving in the same cycle as rst is ignored.

Structure
REQ-031 Package crc_chk_pkg holds the state enum chk_state_t and the queue-depth and counter-width localparams.
REQ-032 The queue is one sub-module, crc_exp_fifo: synchronous, first-word-fall-through, with full/empty outputs; it contains no comparison logic.
REQ-033 All outputs are registered.

Verification
REQ-034 After reset, push 3 expected CRCs 32'hCBF43926, then 3 matching crc_out pulses -> pass_cnt=3, fail_cnt=0, pending=0, fault=0.
REQ-035 Packet 2 of 5 has crc_out mismatched -> fail_cnt=1, first_fail_idx=8'd2, pass_cnt=4.
REQ-036 DEPTH=16: 17 pushes with no pop -> fault=1 the cycle after the 17th push, state FAULT, pending=16.
REQ-037 crc_out_vld with an empty queue and no push -> fault=1, pass_cnt and fail_cnt unchanged.
REQ-038 Simultaneous exp_vld and crc_out_vld with an empty queue and equal values -> pass_cnt +1, pending=0, no fault.
REQ-039 PKT_LIMIT=4, 6 matched packets -> done=1 after the 4th and pass_cnt holds 4; then assert rst -> all outputs return to reset values.

Source files
------------

// File: rtl/crc_chk_pkg.sv
// Shared definitions for the CRC receive checker.
//   chk_state_t  : checker state machine encoding
//   DEF_DEPTH    : default expected-CRC queue depth
//   CNT_W        : width of the packet counters and packet index
//   NO_FAIL_IDX  : first_fail_idx value while no mismatch has been seen
package crc_chk_pkg;

    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] NO_FAIL_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } chk_state_t;

endpackage

// File: rtl/crc_rx_check_if.sv
// Stream-side signals feeding the CRC receive checker.
//   exp_crc / exp_vld     : reference CRC from the stream source, one pulse per packet
//   crc_out / crc_out_vld : CRC result from the engine under test, one pulse per packet
//   master : drives the stream (source / engine side)
//   slave  : observes the stream (checker side)
interface crc_rx_check_if #(
    parameter int unsigned CRC_WIDTH = 32
);
    logic [CRC_WIDTH-1:0] exp_crc;
    logic                 exp_vld;
    logic [CRC_WIDTH-1:0] crc_out;
    logic                 crc_out_vld;

    modport master (output exp_crc, exp_vld, crc_out, crc_out_vld);
    modport slave  (input  exp_crc, exp_vld, crc_out, crc_out_vld);
endinterface

// File: rtl/crc_exp_fifo.sv
// Synchronous first-word-fall-through queue of expected CRCs.
//   clk, rst   : clock and synchronous active-high reset (empties the queue)
//   push       : write push_data; ignored when full unless a pop happens too
//   push_data  : value to enqueue
//   pop        : drop the head entry; ignored when empty
//   head       : current head entry (valid whenever empty=0)
//   full/empty : occupancy flags
//   count      : registered number of stored entries, 0..DEPTH
module crc_exp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/crc_rx_check.sv
// Receive-side CRC checker: queues reference CRCs and compares each engine
// result against the oldest queued reference, counting passes and failures.
//   clk, rst       : clock and synchronous active-high reset
//   stream         : exp_crc/exp_vld and crc_out/crc_out_vld (slave modport)
//   pass_cnt       : packets whose CRCs matched (wraps)
//   fail_cnt       : packets whose CRCs mismatched (saturates at 8'hFF)
//   first_fail_idx : 0-based packet index of the first mismatch, 8'hFF if none
//   done           : PKT_LIMIT packets compared (never set when PKT_LIMIT=0)
//   fault          : queue overflow or orphan result seen
//   pending        : expected CRCs queued but not yet compared
module crc_rx_check
    import crc_chk_pkg::*;
#(
    parameter int unsigned      CRC_WIDTH = 32,
    parameter int unsigned      DEPTH     = DEF_DEPTH,
    parameter logic [CNT_W-1:0] PKT_LIMIT = 8'd100
) (
    input  logic                     clk,
    input  logic                     rst,
    crc_rx_check_if.slave            stream,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [CNT_W-1:0]         first_fail_idx,
    output logic                     done,
    output logic                     fault,
    output logic [$clog2(DEPTH):0]   pending
);

    chk_state_t           state;
    logic [CNT_W-1:0]     cmp_cnt;
    logic                 limit_hit;
    logic                 active;
    logic                 push_req;
    logic                 pop_req;
    logic                 bypass;
    logic                 overflow;
    logic                 orphan;
    logic                 cmp_en;
    logic                 cmp_match;
    logic [CRC_WIDTH-1:0] cmp_ref;
    logic [CRC_WIDTH-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Once the limit is reached the stream is ignored, so the transition cycle
    // into DONE cannot compare one packet too many.
    assign limit_hit = (PKT_LIMIT != '0) && (cmp_cnt == PKT_LIMIT);
    assign active    = ((state == ST_IDLE) || (state == ST_RUN)) && !limit_hit;
    assign push_req  = active && stream.exp_vld;
    assign pop_req   = active && stream.crc_out_vld;
    assign bypass    = push_req && pop_req && fifo_empty;
    assign overflow  = push_req && !pop_req && fifo_full;
    assign orphan    = pop_req && !push_req && fifo_empty;
    assign cmp_en    = pop_req && !orphan;
    assign cmp_ref   = bypass ? stream.exp_crc : fifo_head;
    assign cmp_match = (cmp_ref == stream.crc_out);

    crc_exp_fifo #(
        .WIDTH (CRC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req && !bypass && !overflow),
        .push_data (stream.exp_crc),
        .pop       (pop_req && !bypass),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cmp_cnt        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= NO_FAIL_IDX;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (limit_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (overflow || orphan) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else begin
                        if (push_req || pop_req) state <= ST_RUN;
                        if (cmp_en) begin
                            cmp_cnt <= cmp_cnt + 1'b1;
                            if (cmp_match) begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end else begin
                                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                                // fail_cnt saturates and never returns to zero,
                                // so it marks the first failure unambiguously.
                                if (fail_cnt == '0) first_fail_idx <= cmp_cnt;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_rx_check.sv
// Self-checking bench for crc_rx_check: two instances (default parameters and
// DEPTH=4/PKT_LIMIT=4) share one stimulus stream; a queue-based reference
// model predicts every output each cycle, plus directed literal checks.
module tb_crc_rx_check;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_rx_check_if #(.CRC_WIDTH(32)) bus();

    logic [7:0] pass_a, fail_a, ffi_a, pass_b, fail_b, ffi_b;
    logic       done_a, fault_a, done_b, fault_b;
    logic [4:0] pend_a;
    logic [2:0] pend_b;

    crc_rx_check #(.CRC_WIDTH(32), .DEPTH(16), .PKT_LIMIT(8'd100)) u_a (
        .clk(clk), .rst(rst), .stream(bus),
        .pass_cnt(pass_a), .fail_cnt(fail_a), .first_fail_idx(ffi_a),
        .done(done_a), .fault(fault_a), .pending(pend_a)
    );

    crc_rx_check #(.CRC_WIDTH(32), .DEPTH(4), .PKT_LIMIT(8'd4)) u_b (
        .clk(clk), .rst(rst), .stream(bus),
        .pass_cnt(pass_b), .fail_cnt(fail_b), .first_fail_idx(ffi_b),
        .done(done_b), .fault(fault_b), .pending(pend_b)
    );

    logic [7:0] d_pass [2];
    logic [7:0] d_fail [2];
    logic [7:0] d_ffi  [2];
    logic       d_done [2];
    logic       d_fault[2];
    logic [4:0] d_pend [2];
    assign d_pass[0] = pass_a;  assign d_pass[1] = pass_b;
    assign d_fail[0] = fail_a;  assign d_fail[1] = fail_b;
    assign d_ffi[0]  = ffi_a;   assign d_ffi[1]  = ffi_b;
    assign d_done[0] = done_a;  assign d_done[1] = done_b;
    assign d_fault[0] = fault_a; assign d_fault[1] = fault_b;
    assign d_pend[0] = pend_a;  assign d_pend[1] = {2'b00, pend_b};

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Reference model: expected CRCs wait in a queue; each result consumes the
    // oldest one (or the simultaneous one when nothing is waiting).
    logic [31:0] mq [2][$];
    logic [7:0]  m_pass[2], m_fail[2], m_ffi[2], m_cnt[2];
    bit          m_done[2], m_fault[2];

    function automatic int lim_of(input int k);
        return (k == 0) ? 100 : 4;
    endfunction
    function automatic int dep_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] ref_v;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_pass[k] = 8'd0; m_fail[k] = 8'd0; m_ffi[k] = 8'hFF;
                m_cnt[k] = 8'd0; m_done[k] = 1'b0; m_fault[k] = 1'b0;
            end else if (!m_done[k] && !m_fault[k]) begin
                if (lim_of(k) != 0 && int'(m_cnt[k]) == lim_of(k)) begin
                    m_done[k] = 1'b1;
                end else if (bus.crc_out_vld) begin
                    if (mq[k].size() == 0 && !bus.exp_vld) begin
                        m_fault[k] = 1'b1;
                    end else begin
                        if (mq[k].size() == 0) begin
                            ref_v = bus.exp_crc;
                        end else begin
                            ref_v = mq[k].pop_front();
                            if (bus.exp_vld) mq[k].push_back(bus.exp_crc);
                        end
                        if (ref_v == bus.crc_out) begin
                            m_pass[k] = m_pass[k] + 8'd1;
                        end else begin
                            if (m_fail[k] == 8'd0) m_ffi[k] = m_cnt[k];
                            if (m_fail[k] != 8'hFF) m_fail[k] = m_fail[k] + 8'd1;
                        end
                        m_cnt[k] = m_cnt[k] + 8'd1;
                    end
                end else if (bus.exp_vld) begin
                    if (mq[k].size() == dep_of(k)) m_fault[k] = 1'b1;
                    else mq[k].push_back(bus.exp_crc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (d_pass[k] !== m_pass[k] || d_fail[k] !== m_fail[k] ||
                    d_ffi[k] !== m_ffi[k] || d_done[k] !== m_done[k] ||
                    d_fault[k] !== m_fault[k] || int'(d_pend[k]) != mq[k].size()) begin
                    errors++;
                    $display("FAIL model_u%0d t=%0t: dut pass=%0d fail=%0d ffi=%0d done=%0b fault=%0b pend=%0d; model pass=%0d fail=%0d ffi=%0d done=%0b fault=%0b pend=%0d",
                             k, $time, d_pass[k], d_fail[k], d_ffi[k], d_done[k], d_fault[k], d_pend[k],
                             m_pass[k], m_fail[k], m_ffi[k], m_done[k], m_fault[k], mq[k].size());
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic pu, input logic [31:0] e, input logic po, input logic [31:0] c);
        @(negedge clk);
        bus.exp_vld = pu; bus.exp_crc = e; bus.crc_out_vld = po; bus.crc_out = c;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // A reset cycle may carry stream pulses; they must be discarded.
    task automatic do_reset(input logic noisy);
        @(negedge clk);
        rst = 1'b1;
        bus.exp_vld = noisy; bus.exp_crc = 32'h1234_5678;
        bus.crc_out_vld = noisy; bus.crc_out = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        bus.exp_vld = 1'b0; bus.crc_out_vld = 1'b0;
    endtask

    function automatic logic [31:0] crc_pick(input int unsigned i);
        case (i)
            0:       return 32'hCBF43926;
            1:       return 32'h2144DF1C;
            2:       return 32'hDEADBEEF;
            default: return 32'h00000000;
        endcase
    endfunction

    localparam logic [31:0] GOOD = 32'hCBF43926;
    localparam logic [31:0] BAD  = 32'hCBF43927;

    initial begin
        logic        pu, po;
        int          os, pops;
        bus.exp_vld = 1'b0; bus.crc_out_vld = 1'b0;
        bus.exp_crc = '0;   bus.crc_out = '0;

        do_reset(1'b1);
        chk_on = 1'b1;
        chk("reset_pass", int'(pass_a), 0);
        chk("reset_fail", int'(fail_a), 0);
        chk("reset_ffi", int'(ffi_a), 255);
        chk("reset_done_fault", int'({done_a, fault_a}), 0);
        chk("reset_pending", int'(pend_a), 0);

        // Three queued references, then three matching results.
        for (int i = 0; i < 3; i++) cyc(1'b1, GOOD, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, GOOD);
        idle();
        chk("three_match_pass", int'(pass_a), 3);
        chk("three_match_fail", int'(fail_a), 0);
        chk("three_match_pending", int'(pend_a), 0);
        chk("three_match_fault", int'(fault_a), 0);

        // Five packets, packet 2 mismatched.
        do_reset(1'b0);
        for (int p = 0; p < 5; p++) begin
            cyc(1'b1, GOOD, 1'b0, 32'h0);
            cyc(1'b0, 32'h0, 1'b1, (p == 2) ? BAD : GOOD);
        end
        idle();
        chk("mismatch_fail", int'(fail_a), 1);
        chk("mismatch_ffi", int'(ffi_a), 2);
        chk("mismatch_pass", int'(pass_a), 4);

        // Overflow: 17 pushes into a 16-deep queue.
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, crc_pick(i % 3), 1'b0, 32'h0);
        chk("ovf_before_fault", int'(fault_a), 0);
        idle();
        chk("ovf_fault", int'(fault_a), 1);
        chk("ovf_pending", int'(pend_a), 16);
        cyc(1'b0, 32'h0, 1'b1, GOOD);
        idle();
        chk("ovf_hold_pass", int'(pass_a), 0);

        // Orphan result.
        do_reset(1'b0);
        cyc(1'b0, 32'h0, 1'b1, GOOD);
        idle();
        chk("orphan_fault", int'(fault_a), 1);
        chk("orphan_counts", int'(pass_a) + int'(fail_a), 0);

        // Bypass: push and pop together on an empty queue.
        do_reset(1'b0);
        cyc(1'b1, GOOD, 1'b1, GOOD);
        idle();
        chk("bypass_pass", int'(pass_a), 1);
        chk("bypass_pending", int'(pend_a), 0);
        chk("bypass_fault", int'(fault_a), 0);

        // Limit of 4 on u_b with six matched packets.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, crc_pick(i % 3), 1'b1, crc_pick(i % 3));
        chk("limit_pass4", int'(pass_b), 4);
        chk("limit_done_late", int'(done_b), 0);
        cyc(1'b1, GOOD, 1'b1, GOOD);
        idle();
        chk("limit_done", int'(done_b), 1);
        chk("limit_pass_hold", int'(pass_b), 4);
        chk("limit_a_pass", int'(pass_a), 6);
        do_reset(1'b0);
        chk("limit_rst_done", int'(done_b), 0);
        chk("limit_rst_pass", int'(pass_b), 0);
        chk("limit_rst_ffi", int'(ffi_b), 255);

        // Random, overflow-free traffic long enough for u_a to reach its limit.
        os = 0; pops = 0;
        for (int n = 0; n < 2000 && pops < 110; n++) begin
            pu = ($urandom_range(0, 99) < 55) && (os < 15);
            po = ($urandom_range(0, 99) < 50) && ((os > 0) || pu);
            cyc(pu, crc_pick($urandom_range(0, 3)), po, crc_pick($urandom_range(0, 3)));
            if (pu && !po) os++;
            else if (po && !pu) os--;
            if (po) pops++;
        end
        idle();
        idle();
        chk("rand_a_done", int'(done_a), 1);
        chk("rand_a_total", int'(pass_a) + int'(fail_a), 100);

        // Unconstrained random traffic with periodic (noisy) resets.
        for (int n = 0; n < 300; n++) begin
            if (n % 30 == 0) do_reset(n[0] == 1'b0);
            cyc($urandom_range(0, 99) < 40, crc_pick($urandom_range(0, 3)),
                $urandom_range(0, 99) < 40, crc_pick($urandom_range(0, 3)));
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
